// File: rtl/multmod_seq_if.sv
// Streaming handshake bundle for the mod-(2^N-1) multiplier: operand input
// channel and result output channel, each with its own valid/ready pair.
interface multmod_seq_if #(
    parameter int N = 5
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] y;

    // Producer/consumer side drives operands and result acceptance.
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, y
    );

    // Multiplier side.
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/multmod_seq.sv
// Sequential multiplier modulo M = 2^N - 1: one multiplier bit per clock,
// MSB first, using rotate-left (x2 mod M) and end-around-carry addition.
module multmod_seq #(
    parameter int N  = 5,
    parameter int CW = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    multmod_seq_if.slave  s_if
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_acc;
    logic [N-1:0]  r_opa;
    logic [N-1:0]  r_opb;
    logic [CW-1:0] r_idx;
    logic [N-1:0]  r_y;
    logic          r_in_ready;
    logic          r_out_valid;

    state_t        w_state_nxt;
    logic [N-1:0]  w_acc_nxt;
    logic [N-1:0]  w_opa_nxt;
    logic [N-1:0]  w_opb_nxt;
    logic [CW-1:0] w_idx_nxt;
    logic [N-1:0]  w_y_nxt;

    logic          w_bit;
    logic [N-1:0]  w_rot;
    logic [N:0]    w_sum;
    logic [N-1:0]  w_fold;
    logic [N-1:0]  w_step;

    // Doubling mod 2^N-1 is a rotate; the carry out of the add wraps back in
    // with weight 1 because 2^N == 1 (mod M). The fold cannot overflow N bits.
    assign w_bit  = r_opb[r_idx];
    assign w_rot  = {r_acc[N-2:0], r_acc[N-1]};
    assign w_sum  = {1'b0, w_rot} + {1'b0, r_opa};
    assign w_fold = w_sum[N-1:0] + N'(w_sum[N]);
    assign w_step = w_bit ? w_fold : w_rot;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_opa_nxt   = r_opa;
        w_opb_nxt   = r_opb;
        w_idx_nxt   = r_idx;
        w_y_nxt     = r_y;
        case (r_state)
            ST_IDLE: begin
                if (s_if.in_valid) begin
                    w_opa_nxt   = s_if.a;
                    w_opb_nxt   = s_if.b;
                    w_acc_nxt   = '0;
                    w_idx_nxt   = CW'(N - 1);
                    w_state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                w_acc_nxt = w_step;
                if (r_idx == '0) begin
                    w_state_nxt = ST_DONE;
                    // All-ones is the second encoding of zero; emit canonical 0.
                    w_y_nxt     = (&w_step) ? '0 : w_step;
                end else begin
                    w_idx_nxt = r_idx - 1'b1;
                end
            end
            ST_DONE: begin
                if (s_if.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // NOTE: every register, including the datapath, is cleared by the async
    // reset so an aborted operation leaves nothing behind.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_idx       <= '0;
            r_y         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_opa       <= w_opa_nxt;
            r_opb       <= w_opb_nxt;
            r_idx       <= w_idx_nxt;
            r_y         <= w_y_nxt;
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_DONE);
        end
    end

    assign s_if.in_ready  = r_in_ready;
    assign s_if.out_valid = r_out_valid;
    assign s_if.y         = r_y;

endmodule

// File: tb/tb_multmod_seq.sv
// Self-checking bench for multmod_seq: directed vectors, handshake corner
// sequences, and random/exhaustive operands against (a*b) mod (2^N-1).
module tb_multmod_seq;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    multmod_seq_if #(.N(5)) if5 ();
    multmod_seq_if #(.N(7)) if7 ();

    multmod_seq #(.N(5)) dut5 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .s_if    (if5.slave)
    );

    multmod_seq #(.N(7)) dut7 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .s_if    (if7.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int n;
        int a;
        int b;
        int y;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_mulmod(input int a, input int b, input int n);
        longint m;
        m = (longint'(1) << n) - 1;
        return int'((longint'(a) * longint'(b)) % m);
    endfunction

    // One full transaction on the N=5 instance; lat counts edges from accept to OUT_VALID.
    task automatic op5(input int a, input int b, output int y, output int lat);
        int k;
        k = 0;
        while (!if5.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("op5_in_ready", int'(if5.in_ready), 1);
        if5.a = 5'(a);
        if5.b = 5'(b);
        if5.in_valid = 1'b1;
        @(negedge clk);
        if5.in_valid = 1'b0;
        lat = 0;
        while (!if5.out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("op5_out_valid", int'(if5.out_valid), 1);
        y = int'(if5.y);
        if5.out_ready = 1'b1;
        @(negedge clk);
        if5.out_ready = 1'b0;
    endtask

    task automatic op7(input int a, input int b, output int y, output int lat);
        int k;
        k = 0;
        while (!if7.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("op7_in_ready", int'(if7.in_ready), 1);
        if7.a = 7'(a);
        if7.b = 7'(b);
        if7.in_valid = 1'b1;
        @(negedge clk);
        if7.in_valid = 1'b0;
        lat = 0;
        while (!if7.out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("op7_out_valid", int'(if7.out_valid), 1);
        y = int'(if7.y);
        if7.out_ready = 1'b1;
        @(negedge clk);
        if7.out_ready = 1'b0;
    endtask

    initial begin
        vec_t vecs[12];
        int   y;
        int   lat;
        int   k;
        int   spurious;
        int   ra;
        int   rb;

        checks = 0;
        errors = 0;
        vecs[0]  = '{5, 3, 5, 15};
        vecs[1]  = '{5, 31, 31, 0};
        vecs[2]  = '{5, 30, 30, 1};
        vecs[3]  = '{5, 16, 2, 1};
        vecs[4]  = '{5, 0, 17, 0};
        vecs[5]  = '{5, 31, 7, 0};
        vecs[6]  = '{5, 7, 31, 0};
        vecs[7]  = '{5, 7, 9, 1};
        vecs[8]  = '{5, 12, 4, 17};
        vecs[9]  = '{7, 100, 100, 94};
        vecs[10] = '{7, 127, 5, 0};
        vecs[11] = '{7, 0, 127, 0};

        if5.in_valid = 1'b0; if5.a = '0; if5.b = '0; if5.out_ready = 1'b0;
        if7.in_valid = 1'b0; if7.a = '0; if7.b = '0; if7.out_ready = 1'b0;

        // Reset state.
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", int'(if5.in_ready), 1);
        check("rst_out_valid", int'(if5.out_valid), 0);
        check("rst_y", int'(if5.y), 0);
        check("rst7_in_ready", int'(if7.in_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // A=3, B=5: handshake timing in detail.
        if5.a = 5'd3; if5.b = 5'd5; if5.in_valid = 1'b1;
        @(negedge clk);
        if5.in_valid = 1'b0;
        check("basic_in_ready_low", int'(if5.in_ready), 0);
        lat = 0;
        while (!if5.out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("basic_latency", lat, 5);
        check("basic_y", int'(if5.y), 15);
        check("basic_in_ready_done", int'(if5.in_ready), 0);
        if5.out_ready = 1'b1;
        @(negedge clk);
        if5.out_ready = 1'b0;
        check("basic_out_valid_fall", int'(if5.out_valid), 0);
        check("basic_idle_in_ready", int'(if5.in_ready), 1);
        check("basic_y_kept", int'(if5.y), 15);

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].n == 5) op5(vecs[i].a, vecs[i].b, y, lat);
            else                op7(vecs[i].a, vecs[i].b, y, lat);
            check($sformatf("vec%0d_y", i), y, vecs[i].y);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].n);
        end

        // Backpressure: result held for 20 cycles, IN_VALID pulses ignored.
        if5.a = 5'd7; if5.b = 5'd9; if5.in_valid = 1'b1;
        @(negedge clk);
        if5.in_valid = 1'b0;
        k = 0;
        while (!if5.out_valid && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("bp_latency", k, 5);
        for (int i = 0; i < 20; i++) begin
            if5.in_valid = (i % 3 == 0);
            if5.a = 5'($urandom);
            if5.b = 5'($urandom);
            @(negedge clk);
            check("bp_out_valid", int'(if5.out_valid), 1);
            check("bp_y_hold", int'(if5.y), 1);
            check("bp_in_ready", int'(if5.in_ready), 0);
        end
        if5.in_valid = 1'b0;
        if5.out_ready = 1'b1;
        @(negedge clk);
        if5.out_ready = 1'b0;
        check("bp_released", int'(if5.out_valid), 0);
        check("bp_idle", int'(if5.in_ready), 1);

        // Operand changes during CALC have no effect.
        if5.a = 5'd12; if5.b = 5'd4; if5.in_valid = 1'b1;
        @(negedge clk);
        if5.in_valid = 1'b0;
        k = 0;
        while (!if5.out_valid && k < 60) begin
            if5.a = 5'($urandom);
            if5.b = 5'($urandom);
            @(negedge clk);
            k++;
        end
        check("chg_latency", k, 5);
        check("chg_y", int'(if5.y), 17);
        if5.out_ready = 1'b1;
        @(negedge clk);
        if5.out_ready = 1'b0;

        // Asynchronous reset two edges into CALC.
        if5.a = 5'd9; if5.b = 5'd9; if5.in_valid = 1'b1;
        @(negedge clk);
        if5.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", int'(if5.in_ready), 1);
        check("midrst_out_valid", int'(if5.out_valid), 0);
        check("midrst_y", int'(if5.y), 0);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if5.out_valid) spurious++;
        end
        check("midrst_no_spurious", spurious, 0);
        op5(2, 3, y, lat);
        check("midrst_next_y", y, 6);

        // Random operands against the arithmetic model.
        for (int i = 0; i < 150; i++) begin
            ra = int'($urandom_range(0, 31));
            rb = int'($urandom_range(0, 31));
            op5(ra, rb, y, lat);
            check("rand5_y", y, ref_mulmod(ra, rb, 5));
            ra = int'($urandom_range(0, 127));
            rb = int'($urandom_range(0, 127));
            op7(ra, rb, y, lat);
            check("rand7_y", y, ref_mulmod(ra, rb, 7));
        end

        // Exhaustive N=5.
        for (int ea = 0; ea < 32; ea++) begin
            for (int eb = 0; eb < 32; eb++) begin
                op5(ea, eb, y, lat);
                check($sformatf("exh_%0d_%0d", ea, eb), y, ref_mulmod(ea, eb, 5));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
